noc_output_arbiter: RTL and testbench

Per-output-port switch stage of the mesh router, directly downstream of the route selectors. The five route selectors' outputs for one direction (X+, X−, Y+, Y−, local) feed the five inputs of one instance. The block arbitrates packets round-robin, locks the grant for the whole packet (header through tail), and drives the router output link through a 2-entry output buffer with registered valid and data.

---
 rtl/noc_output_arbiter.sv | 155 +++++++++++++++
 tb/tb_noc_output_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// Output-port switch stage. Round-robin arbitration between packet heads, with the grant held
// for the whole packet. The output link is driven from a 2-entry register buffer.
module noc_output_arbiter #(
    parameter int CHANNELS   = 5,
    parameter int FLIT_WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            i_valid,
    output logic [CHANNELS-1:0]            o_ready,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [FLIT_WIDTH-1:0]          o_flit,
    output logic [CHANNELS-1:0]            o_grant
);

    localparam int IDX_W = $clog2(CHANNELS);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [CHANNELS-1:0]     grant_reg, grant_next;
    logic [IDX_W-1:0]        last_grant_reg, last_grant_next;

    logic [1:0]              count_reg;
    logic [FLIT_WIDTH-1:0]   buf0_reg;   // oldest entry, drives the link directly
    logic [FLIT_WIDTH-1:0]   buf1_reg;

    logic [CHANNELS-1:0]     head_req;
    logic [CHANNELS-1:0]     winner_onehot;
    logic                    winner_found;
    logic [IDX_W-1:0]        winner_idx;
    logic [IDX_W-1:0]        scan_idx;
    logic [FLIT_WIDTH-1:0]   masked_flit [CHANNELS];
    logic [FLIT_WIDTH-1:0]   sel_flit;
    logic                    accept;
    logic                    pop;
    logic                    buf_full;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign head_req[gi]      = i_valid[gi] && i_flit[gi*FLIT_WIDTH + 1];
            assign masked_flit[gi]   = grant_reg[gi] ? i_flit[gi*FLIT_WIDTH +: FLIT_WIDTH] : '0;
            assign winner_onehot[gi] = winner_found && (winner_idx == IDX_W'(gi));
        end
    endgenerate

    // The grant is one-hot, so OR-ing the masked channels selects the owner's flit.
    always_comb begin
        sel_flit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_flit = sel_flit | masked_flit[k];
        end
    end

    // Scan starts just after the previous winner and wraps, so the last owner is considered last.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        scan_idx     = last_grant_reg;
        for (int k = 0; k < CHANNELS; k++) begin
            scan_idx = (scan_idx == IDX_W'(CHANNELS - 1)) ? '0 : scan_idx + IDX_W'(1);
            if (!winner_found && head_req[scan_idx]) begin
                winner_found = 1'b1;
                winner_idx   = scan_idx;
            end
        end
    end

    assign buf_full = (count_reg == 2'd2);
    assign accept   = |(i_valid & o_ready);
    assign pop      = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IDX_W'(CHANNELS - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (winner_found) begin
                    state_next      = BUSY;
                    grant_next      = winner_onehot;
                    last_grant_next = winner_idx;
                end
            end
            BUSY: begin
                // Release on tail acceptance; the tail may still sit in the buffer.
                if (accept && sel_flit[0]) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
        endcase
    end

    always_comb begin
        o_ready = '0;
        if (state_reg == BUSY && !buf_full) begin
            o_ready = grant_reg;
        end
        o_grant = grant_reg;
    end

    // Shift-style FIFO: buf0 always holds the oldest flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 2'd0;
            buf0_reg  <= '0;
            buf1_reg  <= '0;
        end else begin
            case ({accept, pop})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        buf0_reg <= sel_flit;
                    end else begin
                        buf1_reg <= sel_flit;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    buf0_reg  <= buf1_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    if (count_reg == 2'd1) begin
                        buf0_reg <= sel_flit;
                    end else begin
                        buf0_reg <= buf1_reg;
                        buf1_reg <= sel_flit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_valid = (count_reg != 2'd0);
    assign o_flit  = buf0_reg;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter. Per-channel source queues feed the inputs,
// and the output flits and grant order are logged for comparison against expected sequences.
module tb_noc_output_arbiter;

    localparam int CH = 5;
    localparam int FW = 64;

    logic               clk;
    logic               rst;
    logic [CH-1:0]      i_valid;
    logic [CH-1:0]      o_ready;
    logic [CH*FW-1:0]   i_flit;
    logic               o_valid;
    logic               i_ready;
    logic [FW-1:0]      o_flit;
    logic [CH-1:0]      o_grant;

    noc_output_arbiter #(.CHANNELS(CH), .FLIT_WIDTH(FW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_flit  (i_flit),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_flit  (o_flit),
        .o_grant (o_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_fail;

    logic [FW-1:0] src_mem [CH][32];
    logic [4:0]    src_rd [CH];
    logic [4:0]    src_wr [CH];

    logic [FW-1:0] out_log [128];
    int            out_n;
    int            gnt_log [64];
    int            gnt_n;
    logic [CH-1:0] prev_grant;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input int ch, input int seq, input logic h, input logic t);
        logic [7:0] c8;
        logic [5:0] s6;
        c8 = ch[7:0];
        s6 = seq[5:0];
        return {48'h0, c8, s6, h, t};
    endfunction

    task automatic push(input int ch, input logic [FW-1:0] f);
        src_mem[ch][src_wr[ch]] = f;
        src_wr[ch] = src_wr[ch] + 5'd1;
    endtask

    task automatic pkt(input int ch, input int seq0, input int len);
        for (int s = 0; s < len; s++) begin
            push(ch, mk(ch, seq0 + s, s == 0, s == len - 1));
        end
    endtask

    task automatic clear_sources();
        for (int k = 0; k < CH; k++) src_wr[k] = src_rd[k];
    endtask

    // Called at a negedge: drive inputs, note handshakes for the coming edge, advance one cycle.
    task automatic cycle();
        for (int k = 0; k < CH; k++) begin
            if (src_rd[k] != src_wr[k]) begin
                i_valid[k] = 1'b1;
                i_flit[k*FW +: FW] = src_mem[k][src_rd[k]];
            end else begin
                i_valid[k] = 1'b0;
                i_flit[k*FW +: FW] = '0;
            end
        end
        for (int k = 0; k < CH; k++) begin
            if (i_valid[k] && o_ready[k]) src_rd[k] = src_rd[k] + 5'd1;
        end
        if (o_valid && i_ready && !rst) begin
            out_log[out_n] = o_flit;
            out_n++;
            $display("[%0t] out flit %h", $time, o_flit);
        end
        @(negedge clk);
        if (o_grant != '0 && prev_grant == '0) begin
            for (int k = 0; k < CH; k++) begin
                if (o_grant[k]) begin
                    gnt_log[gnt_n] = k;
                    gnt_n++;
                end
            end
        end
        prev_grant = o_grant;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        run(2);
        rst = 1'b0;
    endtask

    int ob;
    int gb;
    int a0;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        out_n      = 0;
        gnt_n      = 0;
        prev_grant = '0;
        i_valid    = '0;
        i_flit     = '0;
        i_ready    = 1'b1;
        rst        = 1'b1;
        for (int k = 0; k < CH; k++) begin
            src_rd[k] = 5'd0;
            src_wr[k] = 5'd0;
        end
        @(negedge clk);

        // Reset state
        run(2);
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_grant", 64'(o_grant), 64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd0);
        check("rst_o_flit", o_flit, 64'd0);
        rst = 1'b0;

        // Single-flit packet on channel 2, payload 0xA5
        ob = out_n;
        push(2, 64'h297);
        cycle();
        check("t1_grant", 64'(o_grant), 64'(5'b00100));
        check("t1_valid_early", 64'(o_valid), 64'd0);
        cycle();
        check("t1_valid", 64'(o_valid), 64'd1);
        check("t1_flit", o_flit, 64'h297);
        check("t1_grant_released", 64'(o_grant), 64'd0);
        run(3);
        check("t1_valid_after", 64'(o_valid), 64'd0);
        check("t1_pulses", 64'(out_n - ob), 64'd1);

        // Three 3-flit packets on channels 0, 1, 3 right after reset
        do_reset();
        ob = out_n;
        gb = gnt_n;
        pkt(0, 0, 3);
        pkt(1, 0, 3);
        pkt(3, 0, 3);
        run(20);
        check("t2_grants", 64'(gnt_n - gb), 64'd3);
        check("t2_grant0", 64'(gnt_log[gb]), 64'd0);
        check("t2_grant1", 64'(gnt_log[gb+1]), 64'd1);
        check("t2_grant2", 64'(gnt_log[gb+2]), 64'd3);
        check("t2_count", 64'(out_n - ob), 64'd9);
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 3; s++) begin
                check("t2_flit", out_log[ob + p*3 + s], mk((p == 2) ? 3 : p, s, s == 0, s == 2));
            end
        end

        // Fairness: channel 4 owns last_grant, then heads on 0 (two packets) and 4
        ob = out_n;
        gb = gnt_n;
        pkt(4, 10, 1);
        run(4);
        pkt(0, 20, 1);
        pkt(0, 21, 1);
        pkt(4, 22, 1);
        run(10);
        check("t3_grants", 64'(gnt_n - gb), 64'd4);
        check("t3_grant0", 64'(gnt_log[gb]), 64'd4);
        check("t3_grant1", 64'(gnt_log[gb+1]), 64'd0);
        check("t3_grant2", 64'(gnt_log[gb+2]), 64'd4);
        check("t3_grant3", 64'(gnt_log[gb+3]), 64'd0);
        check("t3_count", 64'(out_n - ob), 64'd4);
        check("t3_flit0", out_log[ob],   mk(4, 10, 1'b1, 1'b1));
        check("t3_flit1", out_log[ob+1], mk(0, 20, 1'b1, 1'b1));
        check("t3_flit2", out_log[ob+2], mk(4, 22, 1'b1, 1'b1));
        check("t3_flit3", out_log[ob+3], mk(0, 21, 1'b1, 1'b1));

        // Back-pressure with a 4-flit packet on channel 1
        ob = out_n;
        a0 = int'(src_rd[1]);
        i_ready = 1'b0;
        pkt(1, 30, 4);
        cycle();
        cycle();
        check("t4_flit_first", o_flit, mk(1, 30, 1'b1, 1'b0));
        run(4);
        check("t4_accepted", 64'(int'(src_rd[1]) - a0), 64'd2);
        check("t4_ready_low", 64'(o_ready), 64'd0);
        check("t4_valid_held", 64'(o_valid), 64'd1);
        check("t4_flit_held", o_flit, mk(1, 30, 1'b1, 1'b0));
        check("t4_grant_held", 64'(o_grant), 64'(5'b00010));
        i_ready = 1'b1;
        run(8);
        check("t4_count", 64'(out_n - ob), 64'd4);
        for (int s = 0; s < 4; s++) begin
            check("t4_flit", out_log[ob + s], mk(1, 30 + s, s == 0, s == 3));
        end
        check("t4_grant_end", 64'(o_grant), 64'd0);

        // Non-head flit on channel 1 while idle
        ob = out_n;
        a0 = int'(src_rd[1]);
        push(1, mk(1, 40, 1'b0, 1'b0));
        run(4);
        check("t5_not_accepted", 64'(int'(src_rd[1]) - a0), 64'd0);
        check("t5_ready", 64'(o_ready), 64'd0);
        check("t5_grant", 64'(o_grant), 64'd0);
        check("t5_no_output", 64'(out_n - ob), 64'd0);
        clear_sources();
        run(1);

        // Reset mid-packet with one flit buffered, then a fresh packet
        i_ready = 1'b0;
        pkt(3, 50, 3);
        cycle();
        cycle();
        check("t6_buffered", 64'(o_valid), 64'd1);
        rst = 1'b1;
        clear_sources();
        cycle();
        check("t6_rst_valid", 64'(o_valid), 64'd0);
        check("t6_rst_grant", 64'(o_grant), 64'd0);
        check("t6_rst_ready", 64'(o_ready), 64'd0);
        rst = 1'b0;
        i_ready = 1'b1;
        ob = out_n;
        pkt(2, 60, 2);
        run(8);
        check("t6_count", 64'(out_n - ob), 64'd2);
        check("t6_flit0", out_log[ob],   mk(2, 60, 1'b1, 1'b0));
        check("t6_flit1", out_log[ob+1], mk(2, 61, 1'b0, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
